source_arbiter: RTL and testbench

Sequencing controller that shares the single downstream command-byte channel between the script engine and the manual-control path. Changes of the script-mode select take effect only at a clean byte boundary: in-flight data is drained, a guard gap is inserted, and then ownership flips, so the downstream never sees a byte from one source spliced into the other's stream. The block sits between both byte sources and the serial transmit/command decoder. It replaces a bare select on the data lines with a safe, handshaked handover.

---
 rtl/source_arbiter_pkg.sv | 30 +++
 rtl/source_arbiter_out_stage.sv | 33 +++
 rtl/source_arbiter.sv | 134 +++++++++++++
 tb/tb_source_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/source_arbiter_pkg.sv
// Shared types and constants for the source arbiter and its output stage.
package source_arbiter_pkg;

    localparam int unsigned DEFAULT_DATA_W     = 8;
    localparam int unsigned DEFAULT_GAP_CYCLES = 16;

    // Values carried on script_mode / active_mode
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCRIPT = 1'b1;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCRIPT = 2'd1,
        DRAIN  = 2'd2,
        GAP    = 2'd3
    } arbState_t;

    // Gap counter must hold GAP_CYCLES-1 down to 0
    function automatic int unsigned gapCntWidth(input int unsigned gapCycles);
        return $clog2(gapCycles + 1);
    endfunction

    localparam int unsigned DEFAULT_GAP_CNT_W = $clog2(DEFAULT_GAP_CYCLES + 1);

    // Steady state that belongs to a given owner
    function automatic arbState_t ownerState(input logic mode);
        return (mode == MODE_SCRIPT) ? SCRIPT : MANUAL;
    endfunction

endpackage

// File: rtl/source_arbiter_out_stage.sv
// Single-entry valid/ready holding register that drives the downstream byte.
module arb_out_stage
    import source_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              loadEn,
    input  logic [DATA_W-1:0] loadData,
    input  logic              drainReady,
    output logic              holdValid,
    output logic [DATA_W-1:0] holdData,
    output logic              free_c
);

    // Register can take a new byte when empty or being emptied this cycle
    assign free_c = !holdValid || drainReady;

    // Load wins over consume so back-to-back bytes keep valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdValid <= 1'b0;
            holdData  <= '0;
        end else if (loadEn) begin
            holdValid <= 1'b1;
            holdData  <= loadData;
        end else if (drainReady) begin
            holdValid <= 1'b0;
        end
    end

endmodule

// File: rtl/source_arbiter.sv
// Shares one downstream byte channel between the script and manual sources,
// handing over ownership only after draining the output and waiting a gap.
module source_arbiter
    import source_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              script_mode,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              m_valid,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              active_mode,
    output logic              switching
);

    localparam int unsigned     CNT_W    = gapCntWidth(GAP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    arbState_t        state;
    arbState_t        stateNext;
    logic             activeModeNext;
    logic             switchingNext;
    logic [CNT_W-1:0] gapCnt;
    logic [CNT_W-1:0] gapCntNext;
    logic             scriptModeQ;
    logic             pending;
    logic             outFree_c;
    logic             loadEn;
    logic [DATA_W-1:0] loadData;

    // Request is already synchronous; one register stage gives a clean compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scriptModeQ <= MODE_MANUAL;
        end else begin
            scriptModeQ <= script_mode;
        end
    end

    assign pending = (scriptModeQ != active_mode);

    // Owner may push only in its steady state, with no switch pending
    assign s_ready = (state == SCRIPT) && !pending && outFree_c;
    assign m_ready = (state == MANUAL) && !pending && outFree_c;

    // Only the owner's data path is ever sampled
    assign loadEn   = (s_valid && s_ready) || (m_valid && m_ready);
    assign loadData = (active_mode == MODE_SCRIPT) ? s_data : m_data;

    // State, owner, switching flag and gap counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MANUAL;
            active_mode <= MODE_MANUAL;
            switching   <= 1'b0;
            gapCnt      <= '0;
        end else begin
            state       <= stateNext;
            active_mode <= activeModeNext;
            switching   <= switchingNext;
            gapCnt      <= gapCntNext;
        end
    end

    // Handover sequencing: owner -> DRAIN -> GAP -> new owner
    always_comb begin
        stateNext      = state;
        activeModeNext = active_mode;
        switchingNext  = switching;
        gapCntNext     = gapCnt;

        case (state)
            MANUAL, SCRIPT: begin
                if (pending) begin
                    stateNext     = DRAIN;
                    switchingNext = 1'b1;
                end
            end

            DRAIN: begin
                if (!pending) begin
                    // Request withdrawn before the handover committed
                    stateNext     = ownerState(active_mode);
                    switchingNext = 1'b0;
                end else if (!out_valid || out_ready) begin
                    // Nothing can be loaded here, so a consume empties the register
                    stateNext  = GAP;
                    gapCntNext = GAP_LOAD;
                end
            end

            GAP: begin
                // Committed: request changes are only looked at once back in an owner state
                if (gapCnt == '0) begin
                    activeModeNext = !active_mode;
                    stateNext      = ownerState(!active_mode);
                    switchingNext  = 1'b0;
                end else begin
                    gapCntNext = gapCnt - CNT_W'(1);
                end
            end

            default: begin
                stateNext      = MANUAL;
                activeModeNext = MODE_MANUAL;
                switchingNext  = 1'b0;
                gapCntNext     = '0;
            end
        endcase
    end

    arb_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .loadEn     (loadEn),
        .loadData   (loadData),
        .drainReady (out_ready),
        .holdValid  (out_valid),
        .holdData   (out_data),
        .free_c     (outFree_c)
    );

endmodule

// File: tb/tb_source_arbiter.sv
// Self-checking bench for source_arbiter: directed handover scenarios plus
// randomized traffic against a transaction-level ownership/ordering model.
`timescale 1ns/1ps
module tb_source_arbiter;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned GAP    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              script_mode;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              active_mode;
    logic              switching;

    int errors = 0;
    int checks = 0;

    source_arbiter #(.DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .script_mode (script_mode),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .active_mode (active_mode),
        .switching   (switching)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; script_mode = 1'b0; s_valid = 1'b0; m_valid = 1'b0;
        s_data = '0; m_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (active_mode !== 1'b0) begin errors++; $display("FAIL reset_active_mode: got %b want 0", active_mode); end
        checks++; if (switching !== 1'b0) begin errors++; $display("FAIL reset_switching: got %b want 0", switching); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        rst_n = 1'b1;
        tick();
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_m_ready: got %b want 1", m_ready); end
    endtask

    task automatic test_manual_stream();
        logic [7:0] exp [0:2];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_valid = 1'b1; m_data = exp[i];
            @(negedge clk);
            checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL stream_m_ready[%0d]: got %b want 1", i, m_ready); end
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL stream_s_ready[%0d]: got %b want 0", i, s_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp[i]);
            end
        end
        m_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got v=%b want 0", out_valid); end
    endtask

    task automatic test_nonowner();
        logic       expAcc;
        logic [7:0] mByte;
        out_ready = 1'b1; s_valid = 1'b1; s_data = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            m_valid = 1'($urandom_range(0, 1));
            mByte   = 8'($urandom_range(0, 254));
            m_data  = mByte;
            expAcc  = m_valid;
            @(negedge clk);
            checks++; if (s_ready !== 1'b0 || m_ready !== 1'b1) begin
                errors++; $display("FAIL nonowner_ready[%0d]: got s=%b m=%b want s=0 m=1", i, s_ready, m_ready);
            end
            tick();
            checks++; if (out_valid !== expAcc || (expAcc && out_data !== mByte)) begin
                errors++; $display("FAIL nonowner_out[%0d]: got v=%b d=%h want v=%b d=%h", i, out_valid, out_data, expAcc, mByte);
            end
            checks++; if (out_data === 8'hFF) begin errors++; $display("FAIL nonowner_leak[%0d]: got d=%h want not FF", i, out_data); end
        end
        s_valid = 1'b0; m_valid = 1'b0;
        tick();
    endtask

    task automatic test_aborted_switch();
        out_ready = 1'b0; m_valid = 1'b1; m_data = 8'h3C;
        tick();
        m_data = 8'h3D;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin errors++; $display("FAIL abort_hold: got v=%b d=%h want v=1 d=3c", out_valid, out_data); end
        script_mode = 1'b1;
        tick();
        script_mode = 1'b0;
        @(negedge clk);
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL abort_m_ready_pending: got %b want 0", m_ready); end
        tick();
        checks++; if (switching !== 1'b1) begin errors++; $display("FAIL abort_switching: got %b want 1", switching); end
        tick();
        checks++; if (switching !== 1'b0 || active_mode !== 1'b0) begin
            errors++; $display("FAIL abort_return: got sw=%b act=%b want sw=0 act=0", switching, active_mode);
        end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin errors++; $display("FAIL abort_still_held: got v=%b d=%h want v=1 d=3c", out_valid, out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL abort_no_gap: got m_ready=%b want 1", m_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3D) begin errors++; $display("FAIL abort_next_byte: got v=%b d=%h want v=1 d=3d", out_valid, out_data); end
        m_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_dup: got v=%b want 0", out_valid); end
    endtask

    task automatic test_switch_backpressure();
        int idle;
        bit found;
        out_ready = 1'b0; m_valid = 1'b1; m_data = 8'h33;
        tick();
        m_data = 8'h55;
        script_mode = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
        tick();
        @(negedge clk);
        checks++; if (m_ready !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got s=%b m=%b want 0 0", s_ready, m_ready); end
        tick();
        checks++; if (switching !== 1'b1) begin errors++; $display("FAIL bp_switching: got %b want 1", switching); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h33 || s_ready !== 1'b0 || m_ready !== 1'b0) begin
                errors++; $display("FAIL bp_stall[%0d]: got v=%b d=%h s=%b m=%b want v=1 d=33 s=0 m=0", k, out_valid, out_data, s_ready, m_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h33) begin errors++; $display("FAIL bp_deliver: got v=%b d=%h want v=1 d=33", out_valid, out_data); end
        tick();
        idle = 0; found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                found = 1'b1;
            end else begin
                idle++;
                checks++; if (out_valid !== 1'b0 || m_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_gap_idle[%0d]: got v=%b m=%b want 0 0", k, out_valid, m_ready);
                end
                tick();
            end
        end
        checks++; if (!found || idle != GAP) begin errors++; $display("FAIL bp_gap_len: got idle=%0d found=%b want %0d 1", idle, found, GAP); end
        checks++; if (active_mode !== 1'b1 || switching !== 1'b0 || m_ready !== 1'b0) begin
            errors++; $display("FAIL bp_new_owner: got act=%b sw=%b m=%b want 1 0 0", active_mode, switching, m_ready);
        end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL bp_first_script: got v=%b d=%h want v=1 d=a5", out_valid, out_data); end
        s_valid = 1'b0; m_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after: got v=%b want 0", out_valid); end
    endtask

    task automatic test_gap_reversal();
        int n;
        bit found;
        logic expAct, expSw, expM;
        out_ready = 1'b1; s_valid = 1'b0; m_valid = 1'b0;
        script_mode = 1'b0;
        n = 0; found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (m_ready === 1'b1) found = 1'b1;
            else begin n++; tick(); end
        end
        checks++; if (!found || n != int'(GAP) + 3 || active_mode !== 1'b0) begin
            errors++; $display("FAIL rev_back_latency: got n=%0d found=%b act=%b want %0d 1 0", n, found, active_mode, GAP + 3);
        end
        tick();
        script_mode = 1'b1;
        for (int t = 1; t <= 2 * int'(GAP) + 7; t++) begin
            tick();
            if (t == 4) script_mode = 1'b0;
            expAct = (t >= int'(GAP) + 3) && (t < 2 * int'(GAP) + 5);
            expSw  = ((t >= 2) && (t < int'(GAP) + 3)) || ((t >= int'(GAP) + 4) && (t < 2 * int'(GAP) + 5));
            expM   = (t >= 2 * int'(GAP) + 5);
            checks++; if (active_mode !== expAct || switching !== expSw) begin
                errors++; $display("FAIL rev_t%0d: got act=%b sw=%b want act=%b sw=%b", t, active_mode, switching, expAct, expSw);
            end
            @(negedge clk);
            checks++; if (s_ready !== 1'b0 || m_ready !== expM) begin
                errors++; $display("FAIL rev_ready_t%0d: got s=%b m=%b want s=0 m=%b", t, s_ready, m_ready, expM);
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int   idleRun = 0;
        int   flips = 0;
        int   pushes = 0;
        logic prevAct;
        logic modeQ;
        prevAct = active_mode;
        modeQ   = script_mode;
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 24) == 0) script_mode = ~script_mode;
            s_valid   = 1'($urandom_range(0, 1));
            s_data    = 8'($urandom);
            m_valid   = 1'($urandom_range(0, 1));
            m_data    = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++; if (out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, q.size() != 0);
            end
            if (q.size() != 0) begin
                checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, out_data, q[0]); end
            end
            if (s_ready === 1'b1) begin
                checks++; if (!(active_mode === 1'b1 && switching === 1'b0 && modeQ === 1'b1 && (!out_valid || out_ready))) begin
                    errors++; $display("FAIL rnd_s_owner c%0d: got act=%b sw=%b req=%b v=%b want s_ready only for script owner", c, active_mode, switching, modeQ, out_valid);
                end
            end
            if (m_ready === 1'b1) begin
                checks++; if (!(active_mode === 1'b0 && switching === 1'b0 && modeQ === 1'b0 && (!out_valid || out_ready))) begin
                    errors++; $display("FAIL rnd_m_owner c%0d: got act=%b sw=%b req=%b v=%b want m_ready only for manual owner", c, active_mode, switching, modeQ, out_valid);
                end
            end
            if (active_mode !== prevAct) begin
                flips++;
                checks++; if (idleRun < int'(GAP)) begin errors++; $display("FAIL rnd_gap c%0d: got idle=%0d want >=%0d", c, idleRun, GAP); end
            end
            idleRun = (switching === 1'b1 && out_valid === 1'b0) ? idleRun + 1 : 0;
            prevAct = active_mode;
            if (out_valid && out_ready) void'(q.pop_front());
            if (s_valid && s_ready) begin q.push_back(s_data); pushes++; end
            if (m_valid && m_ready) begin q.push_back(m_data); pushes++; end
            modeQ = script_mode;
            tick();
        end
        checks++; if (flips < 4 || pushes < 100) begin errors++; $display("FAIL rnd_activity: got flips=%0d pushes=%0d want >=4 >=100", flips, pushes); end
        s_valid = 1'b0; m_valid = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        int n;
        bit found;
        rst_n = 1'b0; script_mode = 1'b0; s_valid = 1'b0; m_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        script_mode = 1'b1;
        repeat (4) tick();
        checks++; if (switching !== 1'b1) begin errors++; $display("FAIL ar_gap_entry: got sw=%b want 1", switching); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || active_mode !== 1'b0 || switching !== 1'b0) begin
            errors++; $display("FAIL ar_mid_gap: got v=%b act=%b sw=%b want 0 0 0", out_valid, active_mode, switching);
        end
        script_mode = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        script_mode = 1'b1;
        n = 0; found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (s_ready === 1'b1) found = 1'b1;
            else begin n++; tick(); end
        end
        checks++; if (!found || n != int'(GAP) + 3) begin errors++; $display("FAIL ar_switch_latency: got n=%0d found=%b want %0d 1", n, found, GAP + 3); end
        s_valid = 1'b1; s_data = 8'h5A; out_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || active_mode !== 1'b1) begin
            errors++; $display("FAIL ar_held: got v=%b d=%h act=%b want 1 5a 1", out_valid, out_data, active_mode);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || active_mode !== 1'b0 || switching !== 1'b0) begin
            errors++; $display("FAIL ar_held_reset: got v=%b d=%h act=%b sw=%b want 0 00 0 0", out_valid, out_data, active_mode, switching);
        end
        script_mode = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (m_ready !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL ar_post_ready: got s=%b m=%b want 0 1", s_ready, m_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_no_replay: got v=%b want 0", out_valid); end
        m_valid = 1'b1; m_data = 8'h77; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin errors++; $display("FAIL ar_post_byte: got v=%b d=%h want 1 77", out_valid, out_data); end
        m_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_manual_stream();
        test_nonowner();
        test_aborted_switch();
        test_switch_backpressure();
        test_gap_reversal();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
